// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit: one radix-2 step per cycle,
// WIDTH steps per operation, result presented with a one-cycle write-back pulse.
module mul_div_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startOp,
  input  logic [1:0]        opSel,
  input  logic [WIDTH-1:0]  operandA,
  input  logic [WIDTH-1:0]  operandB,
  input  logic [ADDR_W-1:0] destAddress,
  output logic              busy,
  output logic              resultValid,
  output logic [WIDTH-1:0]  resultData,
  output logic [ADDR_W-1:0] resultAddress,
  output logic              regWriteControl,
  output logic [1:0]        stateDbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t              state;
  logic [1:0]          opReg;
  logic [ADDR_W-1:0]   destReg;
  logic [WIDTH-1:0]    aReg;
  logic [WIDTH-1:0]    bReg;
  logic [2*WIDTH-1:0]  prodReg;
  logic [WIDTH:0]      remReg;
  logic [WIDTH-1:0]    quoReg;
  logic [CNT_W-1:0]    iterCount;

  logic [WIDTH:0]      addSum;
  logic [2*WIDTH-1:0]  prodNext;
  logic [WIDTH:0]      remShift;
  logic                remFits;
  logic [WIDTH:0]      remNext;
  logic [WIDTH-1:0]    quoNext;
  logic [WIDTH-1:0]    finalResult;

  // Multiply and divide datapaths step together; opReg only picks the result.
  always_comb begin
    addSum      = {1'b0, prodReg[2*WIDTH-1:WIDTH]} + (prodReg[0] ? {1'b0, aReg} : '0);
    prodNext    = {addSum, prodReg[WIDTH-1:1]};
    remShift    = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
    remFits     = (remShift >= {1'b0, bReg});
    remNext     = remFits ? (remShift - {1'b0, bReg}) : remShift;
    quoNext     = {quoReg[WIDTH-2:0], remFits};
    finalResult = '0;
    case (opReg)
      2'b00:   finalResult = prodNext[WIDTH-1:0];
      2'b01:   finalResult = prodNext[2*WIDTH-1:WIDTH];
      2'b10:   finalResult = quoNext;
      default: finalResult = remNext[WIDTH-1:0];
    endcase
  end

  // Handshake: startOp is taken on a rising edge only while busy=0; busy then
  // stays high until the edge after the resultValid cycle. Requests seen while
  // busy=1 are dropped, never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      resultValid     <= 1'b0;
      regWriteControl <= 1'b0;
      resultData      <= '0;
      resultAddress   <= '0;
      opReg           <= '0;
      destReg         <= '0;
      aReg            <= '0;
      bReg            <= '0;
      prodReg         <= '0;
      remReg          <= '0;
      quoReg          <= '0;
      iterCount       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startOp) begin
            opReg     <= opSel;
            destReg   <= destAddress;
            aReg      <= operandA;
            bReg      <= operandB;
            prodReg   <= {{WIDTH{1'b0}}, operandB};
            remReg    <= '0;
            quoReg    <= operandA;
            iterCount <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          prodReg   <= prodNext;
          remReg    <= remNext;
          quoReg    <= quoNext;
          iterCount <= iterCount + CNT_W'(1);
          if (iterCount == LAST_ITER) begin
            state           <= DONE;
            resultValid     <= 1'b1;
            resultData      <= finalResult;
            resultAddress   <= destReg;
            regWriteControl <= (destReg != '0);
          end
        end
        DONE: begin
          state           <= IDLE;
          busy            <= 1'b0;
          resultValid     <= 1'b0;
          regWriteControl <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stateDbg = state;

endmodule
